// File: rtl/jt1943_inputs.sv
// jt1943_inputs
// Conditions the player inputs for the 1943 core. It merges the PS/2 keyboard
// with the two MiSTer pads and registers the result as active-low game inputs.
// On top of the plain merge it tracks per-key held state, toggles a pause
// latch, and stretches coin pulses to at least COIN_LEN clock cycles.
//
// Parameters
//   COIN_LEN      minimum coin-low pulse length in clk cycles (1 .. 2^20-1)
// Ports
//   clk           system clock (48 MHz); all logic runs on it
//   rst_n         asynchronous active-low reset
//   ps2_key       [10] event toggle, [9] pressed, [8] extended (unused),
//                 [7:0] scan code
//   joy_0/joy_1   pads, active-high: 0 R,1 L,2 D,3 U,4 fire,5 bomb,
//                 6 start1,7 start2,8 coin,9 pause
//   sys_rst_req   OSD/button reset request; forces the game out of pause
//   start_button  {start2, start1}, active-low
//   coin_input    {coin2, coin1}, active-low, stretched
//   joystick1/2   {1, bomb, fire, up, down, left, right}, active-low
//   dip_test      service switch, active-low
//   dip_pause     1 = running, 0 = paused
module jt1943_inputs #(
  parameter int unsigned COIN_LEN = 480000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joy_0,
  input  logic [15:0] joy_1,
  input  logic        sys_rst_req,
  output logic [1:0]  start_button,
  output logic [1:0]  coin_input,
  output logic [6:0]  joystick1,
  output logic [6:0]  joystick2,
  output logic        dip_test,
  output logic        dip_pause
);

  localparam logic [19:0] COIN_LOAD = 20'(COIN_LEN);

  localparam logic [7:0] SC_UP     = 8'h75;
  localparam logic [7:0] SC_DOWN   = 8'h72;
  localparam logic [7:0] SC_LEFT   = 8'h6B;
  localparam logic [7:0] SC_RIGHT  = 8'h74;
  localparam logic [7:0] SC_START1 = 8'h05;
  localparam logic [7:0] SC_START2 = 8'h06;
  localparam logic [7:0] SC_COIN1  = 8'h04;
  localparam logic [7:0] SC_PAUSE  = 8'h0C;
  localparam logic [7:0] SC_TEST   = 8'h03;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_ALT    = 8'h11;
  localparam logic [7:0] SC_SPACE  = 8'h29;

  // Bits of the pad and key words that the game has no use for.
  logic unused_bits;
  assign unused_bits = ^{ps2_key[8], joy_0[15:10], joy_1[15:9], joy_1[7]};

  // ---------------------------------------------------------------------
  // Keyboard held-state registers
  // ---------------------------------------------------------------------
  logic ps2_last;
  logic ps2_event;
  logic key_up, key_down, key_left, key_right;
  logic key_start1, key_start2, key_coin1, key_pause, key_test;
  logic key_ctrl, key_alt, key_bomb;

  assign ps2_event = ps2_key[10] != ps2_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps2_last   <= 1'b0;
      key_up     <= 1'b0;
      key_down   <= 1'b0;
      key_left   <= 1'b0;
      key_right  <= 1'b0;
      key_start1 <= 1'b0;
      key_start2 <= 1'b0;
      key_coin1  <= 1'b0;
      key_pause  <= 1'b0;
      key_test   <= 1'b0;
      key_ctrl   <= 1'b0;
      key_alt    <= 1'b0;
      key_bomb   <= 1'b0;
    end else begin
      ps2_last <= ps2_key[10];
      if (ps2_event) begin
        case (ps2_key[7:0])
          SC_UP:     key_up     <= ps2_key[9];
          SC_DOWN:   key_down   <= ps2_key[9];
          SC_LEFT:   key_left   <= ps2_key[9];
          SC_RIGHT:  key_right  <= ps2_key[9];
          SC_START1: key_start1 <= ps2_key[9];
          SC_START2: key_start2 <= ps2_key[9];
          SC_COIN1:  key_coin1  <= ps2_key[9];
          SC_PAUSE:  key_pause  <= ps2_key[9];
          SC_TEST:   key_test   <= ps2_key[9];
          SC_CTRL:   key_ctrl   <= ps2_key[9];
          SC_ALT:    key_alt    <= ps2_key[9];
          SC_SPACE:  key_bomb   <= ps2_key[9];
          default: ;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------
  // Merge of keyboard and pads (active-high)
  // ---------------------------------------------------------------------
  logic [5:0] p1_act;   // {bomb, fire, up, down, left, right}
  logic [5:0] p2_act;
  logic [1:0] start_act;
  logic [1:0] coin_req;
  logic       pause_req;

  always_comb begin
    p1_act    = '0;
    p2_act    = '0;
    start_act = '0;
    coin_req  = '0;
    pause_req = 1'b0;

    p1_act[0] = key_right | joy_0[0];
    p1_act[1] = key_left  | joy_0[1];
    p1_act[2] = key_down  | joy_0[2];
    p1_act[3] = key_up    | joy_0[3];
    // Two fire keys are tracked separately so releasing one while the other
    // is still held does not drop fire.
    p1_act[4] = key_ctrl | key_alt | joy_0[4];
    p1_act[5] = key_bomb | joy_0[5];

    p2_act = joy_1[5:0];

    start_act[0] = key_start1 | joy_0[6];
    start_act[1] = key_start2 | joy_0[7] | joy_1[6];

    coin_req[0] = key_coin1 | joy_0[8];
    coin_req[1] = joy_1[8];

    pause_req = key_pause | joy_0[9];
  end

  // ---------------------------------------------------------------------
  // Coin stretchers
  // ---------------------------------------------------------------------
  logic [1:0]       coin_last;
  logic [1:0][19:0] coin_cnt;
  logic [1:0][19:0] coin_cnt_nxt;

  always_comb begin
    coin_cnt_nxt = coin_cnt;
    for (int unsigned i = 0; i < 2; i++) begin
      if (coin_req[i] && !coin_last[i]) begin
        // A new edge restarts the full length; it never extends by summing.
        coin_cnt_nxt[i] = COIN_LOAD;
      end else if (coin_cnt[i] != '0) begin
        coin_cnt_nxt[i] = coin_cnt[i] - 20'd1;
      end
    end
  end

  // The output looks at the post-update count so that a single-cycle request
  // yields exactly COIN_LEN low cycles, the first one being the request itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coin_last  <= '0;
      coin_cnt   <= '0;
      coin_input <= '1;
    end else begin
      coin_last <= coin_req;
      coin_cnt  <= coin_cnt_nxt;
      for (int unsigned i = 0; i < 2; i++) begin
        coin_input[i] <= ~(coin_req[i] | (coin_cnt_nxt[i] != '0));
      end
    end
  end

  // ---------------------------------------------------------------------
  // Pause toggle
  // ---------------------------------------------------------------------
  logic pause_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pause_last <= 1'b0;
      dip_pause  <= 1'b1;
    end else begin
      pause_last <= pause_req;
      if (sys_rst_req) begin
        dip_pause <= 1'b1;
      end else if (pause_req && !pause_last) begin
        dip_pause <= ~dip_pause;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Registered active-low outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_button <= '1;
      joystick1    <= '1;
      joystick2    <= '1;
      dip_test     <= 1'b1;
    end else begin
      start_button <= ~start_act;
      joystick1    <= {1'b1, ~p1_act};
      joystick2    <= {1'b1, ~p2_act};
      dip_test     <= ~key_test;
    end
  end

endmodule

// File: tb/tb_jt1943_inputs.sv
module tb_jt1943_inputs;

  localparam int unsigned CL = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [10:0] ps2_key = '0;
  logic [15:0] joy_0 = '0;
  logic [15:0] joy_1 = '0;
  logic        sys_rst_req = 1'b0;
  logic [1:0]  start_button;
  logic [1:0]  coin_input;
  logic [6:0]  joystick1;
  logic [6:0]  joystick2;
  logic        dip_test;
  logic        dip_pause;

  jt1943_inputs #(.COIN_LEN(CL)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ps2_key      (ps2_key),
    .joy_0        (joy_0),
    .joy_1        (joy_1),
    .sys_rst_req  (sys_rst_req),
    .start_button (start_button),
    .coin_input   (coin_input),
    .joystick1    (joystick1),
    .joystick2    (joystick2),
    .dip_test     (dip_test),
    .dip_pause    (dip_pause)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [7:0] code, input logic pr);
    ps2_key = {~ps2_key[10], pr, 1'b0, code};
    tick;
    tick;
  endtask

  task automatic count_low(input int ch, output int n);
    n = 0;
    while (coin_input[ch] == 1'b0 && n < 100) begin
      n++;
      tick;
    end
  endtask

  function automatic logic [19:0] dut_vec();
    return {start_button, coin_input, joystick1, joystick2, dip_test, dip_pause};
  endfunction

  // ---------------- behavioural reference model ----------------
  bit  keys [256];
  bit  m_last10;
  int  cyc;
  int  rise_t [2];
  bit  req_last [2];
  bit  m_pause;
  bit  plast;

  task automatic model_init;
    foreach (keys[i]) keys[i] = 1'b0;
    m_last10 = 1'b0;
    cyc = 0;
    rise_t[0] = -1000;
    rise_t[1] = -1000;
    req_last[0] = 1'b0;
    req_last[1] = 1'b0;
    m_pause = 1'b1;
    plast = 1'b0;
  endtask

  // Expected outputs right after the coming clock edge, given current inputs.
  task automatic model_step(output logic [19:0] e);
    logic [6:0] ej1, ej2;
    logic [1:0] est, ec;
    bit   creq [2];
    bit   preq;
    ej1 = ~{1'b0, keys[8'h29] | joy_0[5], keys[8'h14] | keys[8'h11] | joy_0[4],
            keys[8'h75] | joy_0[3], keys[8'h72] | joy_0[2],
            keys[8'h6B] | joy_0[1], keys[8'h74] | joy_0[0]};
    ej2 = ~{1'b0, joy_1[5:0]};
    est = ~{keys[8'h06] | joy_0[7] | joy_1[6], keys[8'h05] | joy_0[6]};
    creq[0] = keys[8'h04] | joy_0[8];
    creq[1] = joy_1[8];
    for (int i = 0; i < 2; i++) begin
      if (creq[i] && !req_last[i]) rise_t[i] = cyc;
      ec[i] = ~(creq[i] | ((cyc - rise_t[i]) < int'(CL)));
      req_last[i] = creq[i];
    end
    preq = keys[8'h0C] | joy_0[9];
    if (sys_rst_req) m_pause = 1'b1;
    else if (preq && !plast) m_pause = ~m_pause;
    plast = preq;
    e = {est, ec, ej1, ej2, ~keys[8'h03], m_pause};
    if (ps2_key[10] != m_last10) keys[ps2_key[7:0]] = ps2_key[9];
    m_last10 = ps2_key[10];
    cyc++;
  endtask

  typedef struct {
    logic [15:0] j0;
    logic [15:0] j1;
    logic [6:0]  ej1;
    logic [6:0]  ej2;
    logic [1:0]  est;
  } vec_t;

  vec_t tbl [7];
  logic [7:0] codes [12];

  initial begin
    int n;
    int lows;
    logic [19:0] e;

    tbl[0] = '{16'h0001, 16'h0000, 7'b1111110, 7'h7F, 2'b11};
    tbl[1] = '{16'h0030, 16'h0000, 7'b1001111, 7'h7F, 2'b11};
    tbl[2] = '{16'h00C0, 16'h0000, 7'h7F, 7'h7F, 2'b00};
    tbl[3] = '{16'h000C, 16'h0000, 7'b1110011, 7'h7F, 2'b11};
    tbl[4] = '{16'h0000, 16'h0040, 7'h7F, 7'h7F, 2'b01};
    tbl[5] = '{16'h0000, 16'h003F, 7'h7F, 7'b1000000, 2'b11};
    tbl[6] = '{16'h0002, 16'h0011, 7'b1111101, 7'b1101110, 2'b11};
    codes = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h05, 8'h06,
              8'h04, 8'h0C, 8'h03, 8'h14, 8'h11, 8'h29};

    // Reset
    #2 rst_n = 1'b0;
    #2;
    chk("reset_outputs", 32'(dut_vec()), 32'hFFFFF);
    tick;
    rst_n = 1'b1;
    tick;
    tick;
    chk("after_reset_release", 32'(dut_vec()), 32'hFFFFF);

    // Keyboard press/release with two-register latency
    ps2_key = {1'b1, 1'b1, 1'b0, 8'h75};
    tick;
    chk("key_up_latency1", 32'(joystick1[3]), 32'h1);
    tick;
    chk("key_up_pressed", 32'(joystick1[3]), 32'h0);
    key(8'h75, 1'b0);
    chk("key_up_released", 32'(joystick1[3]), 32'h1);
    ps2_key = {ps2_key[10], 1'b1, 1'b0, 8'h72};
    tick;
    tick;
    chk("no_toggle_no_change", 32'(joystick1), 32'h7F);

    // Dual fire keys
    key(8'h14, 1'b1);
    key(8'h11, 1'b1);
    key(8'h14, 1'b0);
    chk("fire_alt_held", 32'(joystick1[4]), 32'h0);
    key(8'h11, 1'b0);
    chk("fire_all_released", 32'(joystick1[4]), 32'h1);

    // Pad merge table
    for (int i = 0; i < 7; i++) begin
      joy_0 = tbl[i].j0;
      joy_1 = tbl[i].j1;
      tick;
      chk($sformatf("pad_vec%0d_j1", i), 32'(joystick1), 32'(tbl[i].ej1));
      chk($sformatf("pad_vec%0d_j2", i), 32'(joystick2), 32'(tbl[i].ej2));
      chk($sformatf("pad_vec%0d_start", i), 32'(start_button), 32'(tbl[i].est));
    end
    joy_0 = '0;
    joy_1 = '0;
    tick;

    // Coin: single-cycle pulse
    joy_0[8] = 1'b1;
    tick;
    joy_0[8] = 1'b0;
    count_low(0, n);
    chk("coin_single_len", 32'(n), 32'(CL));

    // Coin: retrigger three cycles into a pulse
    repeat (3) tick;
    joy_0[8] = 1'b1;
    tick;
    joy_0[8] = 1'b0;
    tick;
    tick;
    chk("coin_first_in_flight", 32'(coin_input[0]), 32'h0);
    joy_0[8] = 1'b1;
    tick;
    joy_0[8] = 1'b0;
    count_low(0, n);
    chk("coin_retrigger_len", 32'(n), 32'(CL));

    // Coin 2: held 20 cycles
    repeat (3) tick;
    joy_1[8] = 1'b1;
    lows = 0;
    repeat (20) begin
      tick;
      if (coin_input[1] == 1'b0) lows++;
    end
    joy_1[8] = 1'b0;
    tick;
    chk("coin2_held_low", 32'(lows), 32'd20);
    chk("coin2_after_release", 32'(coin_input[1]), 32'h1);

    // Pause toggle and override
    joy_0[9] = 1'b1;
    tick;
    chk("pause_first", 32'(dip_pause), 32'h0);
    joy_0[9] = 1'b0;
    tick;
    joy_0[9] = 1'b1;
    tick;
    chk("pause_second", 32'(dip_pause), 32'h1);
    joy_0[9] = 1'b0;
    tick;
    joy_0[9] = 1'b1;
    sys_rst_req = 1'b1;
    tick;
    chk("pause_sysrst_priority", 32'(dip_pause), 32'h1);
    joy_0[9] = 1'b0;
    sys_rst_req = 1'b0;
    tick;
    chk("pause_sysrst_after", 32'(dip_pause), 32'h1);

    // Reset in the middle of a coin pulse
    joy_0[8] = 1'b1;
    tick;
    joy_0[8] = 1'b0;
    tick;
    tick;
    chk("coin_before_midreset", 32'(coin_input[0]), 32'h0);
    rst_n = 1'b0;
    #1;
    chk("coin_midreset_async", 32'(coin_input[0]), 32'h1);
    tick;
    rst_n = 1'b1;
    lows = 0;
    repeat (12) begin
      tick;
      if (coin_input[0] == 1'b0) lows++;
    end
    chk("coin_no_residual", 32'(lows), 32'd0);

    // Randomized run against the reference model
    ps2_key = '0;
    joy_0 = '0;
    joy_1 = '0;
    sys_rst_req = 1'b0;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    model_init();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(3) == 0) begin
        int idx;
        logic [7:0] code;
        idx = $urandom_range(12);
        code = (idx < 12) ? codes[idx] : 8'($urandom);
        ps2_key = {~ps2_key[10], 1'($urandom), 1'($urandom), code};
      end
      if ($urandom_range(3) == 0) joy_0[7:0] = 8'($urandom) & 8'($urandom);
      if ($urandom_range(3) == 0) joy_1[7:0] = 8'($urandom) & 8'($urandom);
      joy_0[8] = ($urandom_range(15) == 0);
      joy_0[9] = ($urandom_range(9) == 0);
      joy_0[15:10] = 6'($urandom);
      joy_1[8] = ($urandom_range(15) == 0);
      joy_1[15:9] = 7'($urandom);
      sys_rst_req = ($urandom_range(31) == 0);
      model_step(e);
      tick;
      if (dut_vec() !== e) begin
        total++;
        bad++;
        $display("FAIL rand_cycle%0d: got %05h expected %05h", c, dut_vec(), e);
      end else begin
        total++;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jt1943_inputs.md
# jt1943_inputs

Player-input conditioning stage for the 1943 MiSTer build. It sits between `hps_io` and `jt1943_game`. It takes the raw PS/2 key event word and the two MiSTer joystick words, and produces the registered, active-low `start_button`, `coin_input`, `joystick1/2`, `dip_test` and `dip_pause` signals the game core expects. It adds three behaviours on top of the plain merge: per-key held-state tracking, a pause toggle, and coin-pulse stretching, so short presses from a keyboard or USB pad always reach the game as valid coin pulses.

## Interface
- `COIN_LEN`, default 480000: minimum coin-low pulse length in `clk` cycles (10 ms at 48 MHz). Legal range is 1 to 2^20-1.
- `clk`  in  1  system clock, 48 MHz. All logic is on this clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `ps2_key`  in  11  bit 10 toggles on every key event; bit 9 = pressed; bit 8 = extended (ignored); bits 7:0 = scan code.
- `joy_0`  in  16  player 1 pad, active-high. Bit 0 R, 1 L, 2 D, 3 U, 4 fire, 5 bomb, 6 start1, 7 start2, 8 coin, 9 pause.
- `joy_1`  in  16  player 2 pad, same bit layout.
- `sys_rst_req`  in  1  OSD/button reset request (`status[0] | buttons[1]`).
- `start_button`  out  2  {start2, start1}, active-low.
- `coin_input`  out  2  {coin2, coin1}, active-low, stretched.
- `joystick1`  out  7  {1'b1, bomb, fire, up, down, left, right}, active-low.
- `joystick2`  out  7  same layout, player 2 (pad only).
- `dip_test`  out  1  active-low service switch.
- `dip_pause`  out  1  1 = game runs, 0 = paused.

## Operation
- **Key event detection**
  - A register `ps2_last` holds `ps2_key[10]`.
  - An event occurs when `ps2_key[10] != ps2_last`.
  - On an event, the key register matching `ps2_key[7:0]` loads `ps2_key[9]`. Unknown codes are ignored.
- **Key map**
  - Arrow keys: 0x75 up, 0x72 down, 0x6B left, 0x74 right.
  - Function keys: 0x05 F1 start1, 0x06 F2 start2, 0x04 F3 coin1, 0x0C F4 pause, 0x03 F5 test.
  - Fire keys: 0x14 Ctrl and 0x11 Alt each have their own register. Fire is their OR, so releasing one key while the other is held keeps fire asserted.
  - 0x29 Space is bomb.
- **Merge (active-high internally)**
  - P1 direction/fire/bomb = key | `joy_0` bit.
  - start1 = F1 | `joy_0[6]`.
  - start2 = F2 | `joy_0[7]` | `joy_1[6]`.
  - coin1 request = F3 | `joy_0[8]`.
  - coin2 request = `joy_1[8]`.
  - pause request = F4 | `joy_0[9]`.
  - P2 = `joy_1` bits only.
  - Each output is the registered inverse of its merged signal. `joystick*[6]` is held at 1.
- **Coin stretcher** (one per coin channel, 20-bit down-counter `cnt`)
  - On a rising edge of the request, `cnt` loads `COIN_LEN`.
  - Otherwise `cnt` decrements while nonzero.
  - `coin_input[i]` = ~(request | (cnt != 0)).
  - A new rising edge while `cnt != 0` reloads `COIN_LEN`. This is a retrigger, not accumulation.
- **Pause**
  - Each rising edge of the pause request toggles `pause_st`.
  - `sys_rst_req` high forces `pause_st = 1` and has priority over a simultaneous toggle edge.
  - `dip_pause = pause_st`.
- **Test**: `dip_test = ~F5`. Pads have no test bit.

## Timing
- **Reset values**
  - All key registers 0, `ps2_last` 0, `cnt` 0.
  - Every active-low output 1, including `joystick*[6]`.
  - `dip_pause` 1.
  - Edge-detect history registers are 0.
- **Pad path latency**: a pad bit change at edge N appears on the output at edge N+1.
- **Keyboard path latency**: a toggle sampled at edge N updates the key register at N and the output at N+1. An event visible before edge N reaches the output after edge N+1, i.e. two registers.
- **Coin timing**
  - A coin request rising at edge N drives `coin_input` low from N+1.
  - After a one-cycle request, the output stays low for exactly `COIN_LEN` cycles after N+1, counting the N+1 cycle.
  - A held request keeps the output low until `max(release, cnt=0)`.
- **Pause timing**: `dip_pause` changes at the edge after the rising edge is detected, i.e. N+1 from the request rising at N.
- **Mid-operation reset**: asserting `rst_n` low at any time immediately returns all outputs to their reset values and clears all counters. An in-flight coin pulse is abandoned.
- **Simultaneous key and pad**: the outputs are an OR. Releasing one source while the other is held does not deassert the output.

## Test plan
- **Reset**: hold `rst_n`=0, all inputs 0 → all outputs 1 and `dip_pause`=1. Release; after 2 cycles outputs are unchanged.
- **Keyboard press/release**
  - `ps2_key` = {toggle, 1, 0, 8'h75} → `joystick1[3]`=0 two cycles later.
  - Toggle again with pressed=0 → `joystick1[3]`=1.
  - Toggle with no code change and bit 10 steady → no change.
- **Dual fire keys**: press Ctrl, press Alt, release Ctrl → `joystick1[4]` stays 0. Release Alt → `joystick1[4]`=1.
- **Coin stretch** (`COIN_LEN`=8)
  - A one-cycle `joy_0[8]` pulse → `coin_input[0]`=0 for exactly 8 cycles.
  - A second pulse 3 cycles into the first → low for 8 cycles after the second.
  - `joy_1[8]` held for 20 cycles → `coin_input[1]`=0 for 20 cycles.
- **Pause**
  - Two `joy_0[9]` pulses → `dip_pause` goes 1→0→1.
  - A pulse coinciding with `sys_rst_req`=1 → `dip_pause` stays 1.
- **Reset mid-coin**: `rst_n`=0 at cycle 3 of an 8-cycle coin pulse → `coin_input[0]`=1 immediately. After release, no residual low.
